// File: rtl/layer0_input_packer.sv
// layer0_input_packer: quantizes signed samples to Q_W-bit features and packs
// NUM_FEAT of them into one vector for the layer-0 input register.
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_data/s_last sample in;
//   m_valid/m_ready/m_data packed vector out; err_frame sticky framing error;
//   sat_cnt saturated-feature count (live only with LAYER0_PACK_SATSTATS_EN).
module layer0_input_packer #(
  parameter int NUM_FEAT = 4,
  parameter int IN_W     = 16,
  parameter int Q_W      = 2,
  parameter int SHIFT    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_W-1:0]         s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NUM_FEAT*Q_W-1:0] m_data,
  output logic                    err_frame,
  output logic [15:0]             sat_cnt
);

  localparam int VW    = NUM_FEAT * Q_W;
  localparam int IDX_W = $clog2(NUM_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic signed [IN_W-1:0] Q_MAX = IN_W'((1 << (Q_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] Q_MIN = IN_W'(-(1 << (Q_W - 1)));

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [VW-1:0]    col_q;
  logic [VW-1:0]    col_d;
  logic [VW-1:0]    mdat_q;
  logic             mval_q;
  logic             err_q;

  logic signed [IN_W-1:0] sh;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [Q_W-1:0]         q;
  logic                   accept;
  logic                   close;
  logic                   out_free;

  assign sh     = $signed(s_data) >>> SHIFT;
  assign sat_hi = sh > Q_MAX;
  assign sat_lo = sh < Q_MIN;
  assign q      = sat_hi ? Q_MAX[Q_W-1:0] :
                  sat_lo ? Q_MIN[Q_W-1:0] : sh[Q_W-1:0];

  assign s_ready  = (state_q == FILL);
  assign accept   = s_valid && s_ready;
  assign close    = s_last || (idx_q == LAST_IDX);
  assign out_free = !mval_q || m_ready;

  // Features past the write index are still zero in col_q, so a short
  // vector closed by s_last comes out zero-padded.
  always_comb begin
    col_d = col_q;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (idx_q == IDX_W'(k)) col_d[k*Q_W +: Q_W] = q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      col_q   <= '0;
      mdat_q  <= '0;
      mval_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (mval_q && m_ready) mval_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (accept) begin
            if (close) begin
              idx_q <= '0;
              if (s_last != (idx_q == LAST_IDX)) err_q <= 1'b1;
              if (out_free) begin
                mdat_q <= col_d;
                mval_q <= 1'b1;
                col_q  <= '0;
              end else begin
                col_q   <= col_d;
                state_q <= HOLD;
              end
            end else begin
              col_q <= col_d;
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_free) begin
            mdat_q  <= col_q;
            mval_q  <= 1'b1;
            col_q   <= '0;
            idx_q   <= '0;
            state_q <= FILL;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_data    = mdat_q;
  assign m_valid   = mval_q;
  assign err_frame = err_q;

`ifdef LAYER0_PACK_SATSTATS_EN
  logic [15:0] sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else if (accept && (sat_hi || sat_lo) && sat_q != 16'hFFFF) begin
      sat_q <= sat_q + 1'b1;
    end
  end

  assign sat_cnt = sat_q;
`else
  assign sat_cnt = 16'h0000;
`endif

endmodule
